ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
Game controller for the 3x3 tic-tac-toe board. It takes raw move requests from the input layer and sequences each one into the grid-storage block: it clears the board, drives player and move, samples the grid's valid flag, and alternates turns. It evaluates win/tie from the nine grid cell values and publishes the outcome to the display/top level.

Parameters:
FIRST_PLAYER, 2'b01, player that moves first after every clear (2'b01 = P1, 2'b10 = P2)
TIMEOUT_CYCLES, 32'd50_000_000, per-turn idle limit; used only with MOVE_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  level-sampled; begin or restart a game
move_req  in  1  one-cycle strobe; move_sel is valid
move_sel  in  4  square code: 1..9 = A1,A2,A3,B1,B2,B3,C1,C2,C3
grid_cells  in  18  {C3,C2,C1,B3,B2,B1,A3,A2,A1}, 2 bits each (00 empty, 01 P1, 10 P2)
grid_valid  in  1  registered accept flag from the grid block
grid_clear  out  1  board clear to the grid block
grid_player  out  2  player value written by the grid block
grid_move  out  4  square code to the grid block; 0 = no access
cur_player  out  2  player whose turn it is
outcome  out  2  00 in progress, 01 P1 win, 10 P2 win, 11 tie
move_ok  out  1  one-cycle pulse: move accepted
move_bad  out  1  one-cycle pulse: move rejected
busy  out  1  high in CLEAR, ISSUE, CHECK, EVAL

Behaviour:
- Reset values: state IDLE, grid_clear 0, grid_move 0, grid_player 00, cur_player 00, outcome 00, move_ok 0, move_bad 0, busy 0, move counter 0.
- States: IDLE, CLEAR, WAIT_MOVE, ISSUE, CHECK, EVAL, DONE.
- IDLE: on start, go to CLEAR.
- CLEAR: grid_clear=1 for exactly one cycle. Set cur_player=FIRST_PLAYER, counter=0, outcome=00, then go to WAIT_MOVE.
- WAIT_MOVE: grid_move=0.
  - move_req with move_sel in 1..9: register the code, go to ISSUE.
  - move_req with move_sel of 0 or 10..15: pulse move_bad, stay in WAIT_MOVE, no grid access.
  - start has priority over move_req and goes to CLEAR (restart mid-game).
- ISSUE: grid_move=code and grid_player=cur_player for exactly one cycle, then go to CHECK.
- CHECK: grid_move=0; sample grid_valid.
  - grid_valid=1: increment counter, go to EVAL.
  - grid_valid=0: pulse move_bad, same player, go to WAIT_MOVE.
- EVAL: test all 8 lines (3 rows, 3 cols, 2 diagonals) for three equal non-zero cells. Pulse move_ok in every case.
  - Line owned by cur_player: outcome=cur_player, go to DONE.
  - Else counter==9: outcome=11, go to DONE.
  - Else toggle cur_player (01<->10), go to WAIT_MOVE.
- Accept latency: move_req to move_ok is 3 cycles (ISSUE, CHECK, EVAL).
- move_req while busy or in DONE/IDLE: ignored, with no pulse.
- start in ISSUE/CHECK/EVAL: the in-flight move completes through EVAL, then CLEAR follows. start is held as pending in a 1-bit flag.
- DONE: outcome and cur_player hold; start goes to CLEAR.
- Counter is 4 bits and saturates at 9.
- Only one of move_ok/move_bad may be high in any cycle.
- Reset mid-operation: immediate return to reset values. The grid is not cleared until the next start.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined: a 32-bit counter runs in WAIT_MOVE and reloads on entry and on every move_req. On reaching TIMEOUT_CYCLES-1, the turn is forfeited: move_bad pulses, cur_player toggles, and the counter reloads.
- Undefined: no counter is present and WAIT_MOVE waits indefinitely.

Decomposition:
- Shared package/include (ttt_defs):
  - square codes SQ_A1..SQ_C3 = 1..9
  - players P_NONE=00, P1=01, P2=10
  - outcomes OUT_PLAY/OUT_P1/OUT_P2/OUT_TIE
  - FSM state encoding
- Sub-module ttt_win_check: purely combinational. Takes grid_cells and returns winner[1:0] (00 = none), reused later by an AI opponent.

Test Plan:
- Reset, then start → grid_clear high for 1 cycle; cur_player=01; outcome=00.
- P1 plays 1,2,3 and P2 plays 4,5 alternately (grid model accepts all) → move_ok pulses 3 cycles after each req; outcome=01 after the 5th accept; later move_req ignored.
- P1 plays 5, then P2 plays 5 (grid_valid=0) → move_bad pulse; cur_player stays 10; counter=1.
- move_sel=0 and move_sel=12 → move_bad pulse in the next cycle; grid_move stays 0.
- Draw sequence 1,2,3,5,4,6,8,7,9 → outcome=11 after the 9th accept.
- Start pulsed during CHECK → current move evaluated, then grid_clear, outcome=00, cur_player=FIRST_PLAYER. With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=10, idle for 10 cycles → move_bad and cur_player toggles.

Source files
------------

// File: rtl/ttt_defs_pkg.sv
// ---------------------------------------------------------------------------
// ttt_defs_pkg
// Shared definitions for the tic-tac-toe blocks: square codes, player and
// outcome encodings, the turn controller's FSM states and small helpers for
// addressing the packed grid vector.
// ---------------------------------------------------------------------------
package ttt_defs_pkg;

    // Square codes as carried on move_sel / grid_move (0 = no access)
    localparam logic [3:0] SQ_NONE = 4'd0;
    localparam logic [3:0] SQ_A1   = 4'd1;
    localparam logic [3:0] SQ_A2   = 4'd2;
    localparam logic [3:0] SQ_A3   = 4'd3;
    localparam logic [3:0] SQ_B1   = 4'd4;
    localparam logic [3:0] SQ_B2   = 4'd5;
    localparam logic [3:0] SQ_B3   = 4'd6;
    localparam logic [3:0] SQ_C1   = 4'd7;
    localparam logic [3:0] SQ_C2   = 4'd8;
    localparam logic [3:0] SQ_C3   = 4'd9;

    // Cell / player values
    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P1     = 2'b01;
    localparam logic [1:0] P2     = 2'b10;

    // Game outcome
    localparam logic [1:0] OUT_PLAY = 2'b00;
    localparam logic [1:0] OUT_P1   = 2'b01;
    localparam logic [1:0] OUT_P2   = 2'b10;
    localparam logic [1:0] OUT_TIE  = 2'b11;

    // A full board holds nine marks; the move counter saturates here
    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_MOVE,
        ST_ISSUE,
        ST_CHECK,
        ST_EVAL,
        ST_DONE
    } state_t;

    function automatic logic sq_valid(input logic [3:0] code);
        return (code >= SQ_A1) && (code <= SQ_C3);
    endfunction

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

    // Cell value of a square code in the packed grid {C3,...,A1}
    function automatic logic [1:0] cell_of(input logic [17:0] cells, input logic [3:0] sq);
        return cells[2*(sq - 4'd1) +: 2];
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// ---------------------------------------------------------------------------
// ttt_win_check
// Purely combinational line detector for the 3x3 board. Scans the three rows,
// three columns and two diagonals for three equal non-empty cells.
//
// Ports
//   grid_cells  in  18  {C3,C2,C1,B3,B2,B1,A3,A2,A1}, 2 bits per cell
//   winner      out  2  bit0 = P1 owns a line, bit1 = P2 owns a line
//                       (00 none, 01 P1, 10 P2; 11 only on an impossible board)
// ---------------------------------------------------------------------------
module ttt_win_check
    import ttt_defs_pkg::*;
(
    input  logic [17:0] grid_cells,
    output logic [1:0]  winner
);

    localparam logic [3:0] LINES [8][3] = '{
        '{SQ_A1, SQ_A2, SQ_A3},
        '{SQ_B1, SQ_B2, SQ_B3},
        '{SQ_C1, SQ_C2, SQ_C3},
        '{SQ_A1, SQ_B1, SQ_C1},
        '{SQ_A2, SQ_B2, SQ_C2},
        '{SQ_A3, SQ_B3, SQ_C3},
        '{SQ_A1, SQ_B2, SQ_C3},
        '{SQ_A3, SQ_B2, SQ_C1}
    };

    function automatic logic [1:0] line_owner(input logic [1:0] a, input logic [1:0] b,
                                              input logic [1:0] c);
        return ((a == b) && (b == c)) ? a : P_NONE;
    endfunction

    // Owners are OR-ed together so the caller can ask "does this player own
    // any line" with a simple mask rather than relying on scan order.
    always_comb begin
        winner = P_NONE;
        for (int i = 0; i < 8; i++) begin
            winner = winner | line_owner(cell_of(grid_cells, LINES[i][0]),
                                         cell_of(grid_cells, LINES[i][1]),
                                         cell_of(grid_cells, LINES[i][2]));
        end
    end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_turn_ctrl
// Game controller for 3x3 tic-tac-toe. Clears the board on start, sequences
// each move request into the grid block (ISSUE -> CHECK -> EVAL), alternates
// turns, and reports win / tie from the grid cell values.
//
// Optional build macro: MOVE_TIMEOUT_EN -- when defined, a turn left idle for
// TIMEOUT_CYCLES cycles in WAIT_MOVE is forfeited (move_bad, player toggles).
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-low reset
//   start        in   1  level-sampled game start / restart
//   move_req     in   1  one-cycle strobe, move_sel valid
//   move_sel     in   4  square code 1..9 (A1..C3)
//   grid_cells   in  18  board contents from the grid block
//   grid_valid   in   1  registered accept flag from the grid block
//   grid_clear   out  1  board clear to the grid block
//   grid_player  out  2  player written by the grid block
//   grid_move    out  4  square code to the grid block, 0 = no access
//   cur_player   out  2  player to move
//   outcome      out  2  00 play, 01 P1 win, 10 P2 win, 11 tie
//   move_ok      out  1  move accepted pulse (during EVAL)
//   move_bad     out  1  move rejected pulse
//   busy         out  1  high in CLEAR, ISSUE, CHECK, EVAL
// ---------------------------------------------------------------------------
module ttt_turn_ctrl
    import ttt_defs_pkg::*;
#(
    parameter logic [1:0]  FIRST_PLAYER   = 2'b01,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_req,
    input  logic [3:0]  move_sel,
    input  logic [17:0] grid_cells,
    input  logic        grid_valid,
    output logic        grid_clear,
    output logic [1:0]  grid_player,
    output logic [3:0]  grid_move,
    output logic [1:0]  cur_player,
    output logic [1:0]  outcome,
    output logic        move_ok,
    output logic        move_bad,
    output logic        busy
);

    state_t     state, state_d;
    logic [3:0] code_q, code_d;
    logic [1:0] player_d;
    logic [1:0] outcome_d;
    logic [3:0] move_cnt, move_cnt_d;
    logic       start_pend, start_pend_d;
    logic       move_bad_d;
    logic       tmo_fire;
    logic [1:0] winner;

    ttt_win_check u_win_check (
        .grid_cells (grid_cells),
        .winner     (winner)
    );

`ifdef MOVE_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_fire = (state == ST_WAIT_MOVE) && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

    // Reload while outside WAIT_MOVE so every turn starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if ((state != ST_WAIT_MOVE) || move_req || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_fire       = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d      = state;
        code_d       = code_q;
        player_d     = cur_player;
        outcome_d    = outcome;
        move_cnt_d   = move_cnt;
        start_pend_d = start_pend;
        move_bad_d   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end

            ST_CLEAR: begin
                player_d     = FIRST_PLAYER;
                move_cnt_d   = '0;
                outcome_d    = OUT_PLAY;
                start_pend_d = 1'b0;
                state_d      = ST_WAIT_MOVE;
            end

            ST_WAIT_MOVE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end else if (move_req) begin
                    if (sq_valid(move_sel)) begin
                        code_d  = move_sel;
                        state_d = ST_ISSUE;
                    end else begin
                        move_bad_d = 1'b1;
                    end
                end else if (tmo_fire) begin
                    move_bad_d = 1'b1;
                    player_d   = other_player(cur_player);
                end
            end

            ST_ISSUE: begin
                start_pend_d = start_pend | start;
                state_d      = ST_CHECK;
            end

            ST_CHECK: begin
                start_pend_d = start_pend | start;
                if (grid_valid) begin
                    move_cnt_d = (move_cnt >= MAX_MOVES) ? MAX_MOVES : move_cnt + 4'd1;
                    state_d    = ST_EVAL;
                end else begin
                    // Occupied square: same player tries again unless a
                    // restart is already waiting.
                    move_bad_d = 1'b1;
                    state_d    = (start_pend | start) ? ST_CLEAR : ST_WAIT_MOVE;
                end
            end

            ST_EVAL: begin
                // Only the player who just moved can have completed a line.
                if ((winner & cur_player) != P_NONE) begin
                    outcome_d = cur_player;
                    state_d   = ST_DONE;
                end else if (move_cnt == MAX_MOVES) begin
                    outcome_d = OUT_TIE;
                    state_d   = ST_DONE;
                end else begin
                    player_d = other_player(cur_player);
                    state_d  = ST_WAIT_MOVE;
                end
                if (start_pend | start) state_d = ST_CLEAR;
            end

            ST_DONE: begin
                if (start) state_d = ST_CLEAR;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            code_q     <= SQ_NONE;
            cur_player <= P_NONE;
            outcome    <= OUT_PLAY;
            move_cnt   <= '0;
            start_pend <= 1'b0;
            move_bad   <= 1'b0;
        end else begin
            state      <= state_d;
            code_q     <= code_d;
            cur_player <= player_d;
            outcome    <= outcome_d;
            move_cnt   <= move_cnt_d;
            start_pend <= start_pend_d;
            move_bad   <= move_bad_d;
        end
    end

    // Grid strobes and move_ok decode straight from the state, so they last
    // exactly one cycle each.
    assign grid_clear  = (state == ST_CLEAR);
    assign grid_move   = (state == ST_ISSUE) ? code_q : SQ_NONE;
    assign grid_player = (state == ST_ISSUE) ? cur_player : P_NONE;
    assign move_ok     = (state == ST_EVAL);
    assign busy        = (state == ST_CLEAR) || (state == ST_ISSUE) ||
                         (state == ST_CHECK) || (state == ST_EVAL);

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_turn_ctrl
// Bench for ttt_turn_ctrl: a behavioural grid block plus a board-level game
// model predict every pulse, player and outcome. Directed games cover the
// main scenarios, then random games stress the controller.
// ---------------------------------------------------------------------------
module tb_ttt_turn_ctrl;

    localparam logic [1:0] FIRST = 2'b01;
`ifdef MOVE_TIMEOUT_EN
    localparam logic [31:0] TMO = 32'd10;
`else
    localparam logic [31:0] TMO = 32'd50_000_000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        move_req = 1'b0;
    logic [3:0]  move_sel = 4'd0;
    logic [17:0] grid_cells;
    logic        grid_valid;
    logic        grid_clear;
    logic [1:0]  grid_player;
    logic [3:0]  grid_move;
    logic [1:0]  cur_player;
    logic [1:0]  outcome;
    logic        move_ok;
    logic        move_bad;
    logic        busy;

    always #5 clk = ~clk;

    ttt_turn_ctrl #(
        .FIRST_PLAYER   (FIRST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .move_req    (move_req),
        .move_sel    (move_sel),
        .grid_cells  (grid_cells),
        .grid_valid  (grid_valid),
        .grid_clear  (grid_clear),
        .grid_player (grid_player),
        .grid_move   (grid_move),
        .cur_player  (cur_player),
        .outcome     (outcome),
        .move_ok     (move_ok),
        .move_bad    (move_bad),
        .busy        (busy)
    );

    // Behavioural grid block: writes empty squares, flags accept one cycle later.
    logic [17:0] g_cells = '0;
    logic        g_valid = 1'b0;
    assign grid_cells = g_cells;
    assign grid_valid = g_valid;

    always @(posedge clk) begin
        g_valid <= 1'b0;
        if (grid_clear) begin
            g_cells <= '0;
        end else if (grid_move >= 4'd1 && grid_move <= 4'd9) begin
            if (g_cells[2*(grid_move - 4'd1) +: 2] == 2'b00) begin
                g_cells[2*(grid_move - 4'd1) +: 2] <= grid_player;
                g_valid <= 1'b1;
            end
        end
    end

    // Game model
    int         total = 0;
    int         bad = 0;
    logic [1:0] m_board [9];
    logic [1:0] m_player = 2'b00;
    logic [1:0] m_outcome = 2'b00;
    int         m_count = 0;
    bit         m_live = 1'b0;
    int         m_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                   '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit owns_line(input logic [1:0] p);
        for (int l = 0; l < 8; l++)
            if (m_board[m_lines[l][0]] == p && m_board[m_lines[l][1]] == p &&
                m_board[m_lines[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_new_game();
        for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
        m_player  = FIRST;
        m_outcome = 2'b00;
        m_count   = 0;
        m_live    = 1'b1;
    endtask

    // Called at a negedge with no move in flight; returns at a negedge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        check("clear_pulse", grid_clear, 1'b1);
        start = 1'b0;
        @(negedge clk);
        model_new_game();
        check("clear_once", grid_clear, 1'b0);
        check("start_player", cur_player, m_player);
        check("start_outcome", outcome, m_outcome);
    endtask

    // Issues one move request; optionally pulses start during the CHECK cycle.
    task automatic do_move(input logic [3:0] sel, input bit start_in_check);
        int         ok_c = 0, bad_c = 0, clr_c = 0;
        bit         issue = 1'b0;
        logic [1:0] mover = m_player;
        logic [5:1] ok_v = '0, bad_v = '0, clr_v = '0;
        logic [5:1] e_ok = '0, e_bad = '0, e_clr = '0;
        logic [3:0] gm1 = '0;
        logic [1:0] gp1 = '0;
        logic       busy1 = 1'b0;

        if (m_live) begin
            if (sel < 4'd1 || sel > 4'd9) begin
                bad_c = 1;
            end else if (m_board[sel - 4'd1] != 2'b00) begin
                issue = 1'b1;
                bad_c = 3;
                clr_c = start_in_check ? 3 : 0;
            end else begin
                issue = 1'b1;
                ok_c  = 3;
                clr_c = start_in_check ? 4 : 0;
                m_board[sel - 4'd1] = m_player;
                m_count++;
                if (owns_line(m_player)) begin
                    m_outcome = m_player;
                    m_live    = 1'b0;
                end else if (m_count == 9) begin
                    m_outcome = 2'b11;
                    m_live    = 1'b0;
                end else begin
                    m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
                end
            end
        end
        if (ok_c != 0) e_ok[ok_c] = 1'b1;
        if (bad_c != 0) e_bad[bad_c] = 1'b1;
        if (clr_c != 0) e_clr[clr_c] = 1'b1;

        move_req = 1'b1;
        move_sel = sel;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ok_v[c]  = move_ok;
            bad_v[c] = move_bad;
            clr_v[c] = grid_clear;
            if (c == 1) begin
                gm1      = grid_move;
                gp1      = grid_player;
                busy1    = busy;
                move_req = 1'b0;
                if (start_in_check) start = 1'b1;
            end
            if (c == 2) start = 1'b0;
        end
        if (start_in_check) model_new_game();

        check("ok_timing", ok_v, e_ok);
        check("bad_timing", bad_v, e_bad);
        check("clr_timing", clr_v, e_clr);
        check("grid_move", gm1, issue ? sel : 4'd0);
        check("grid_player", gp1, issue ? mover : 2'b00);
        check("busy_issue", busy1, issue);
        check("cur_player", cur_player, m_player);
        check("outcome", outcome, m_outcome);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] sel;
        bit         seen;

        repeat (3) @(negedge clk);
        check("rst_clear", grid_clear, 1'b0);
        check("rst_move", grid_move, 4'd0);
        check("rst_gplayer", grid_player, 2'b00);
        check("rst_player", cur_player, 2'b00);
        check("rst_outcome", outcome, 2'b00);
        check("rst_ok", move_ok, 1'b0);
        check("rst_bad", move_bad, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Requests before any start are ignored.
        do_move(4'd5, 1'b0);

        // P1 wins row A; later requests ignored.
        do_start();
        do_move(4'd1, 1'b0); do_move(4'd4, 1'b0); do_move(4'd2, 1'b0);
        do_move(4'd5, 1'b0); do_move(4'd3, 1'b0);
        check("p1_win", outcome, 2'b01);
        do_move(4'd6, 1'b0);

        // Occupied square and bad codes.
        do_start();
        do_move(4'd5, 1'b0); do_move(4'd5, 1'b0);
        check("retry_player", cur_player, 2'b10);
        do_move(4'd0, 1'b0); do_move(4'd12, 1'b0);

        // Draw.
        do_start();
        do_move(4'd1, 1'b0); do_move(4'd2, 1'b0); do_move(4'd3, 1'b0);
        do_move(4'd5, 1'b0); do_move(4'd4, 1'b0); do_move(4'd6, 1'b0);
        do_move(4'd8, 1'b0); do_move(4'd7, 1'b0); do_move(4'd9, 1'b0);
        check("tie", outcome, 2'b11);

        // Restart arriving while a move is in CHECK.
        do_start();
        do_move(4'd5, 1'b0);
        do_move(4'd1, 1'b1);

`ifdef MOVE_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge clk);
            if (move_bad) seen = 1'b1;
        end
        check("timeout_bad", seen, 1'b1);
        check("timeout_no_ok", move_ok, 1'b0);
        m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
        check("timeout_player", cur_player, m_player);
`endif

        // Reset while a move is in ISSUE.
        move_req = 1'b1;
        move_sel = 4'd2;
        @(negedge clk);
        move_req = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_move", grid_move, 4'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_player", cur_player, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        m_live = 1'b0; m_player = 2'b00; m_outcome = 2'b00;
        @(negedge clk);

        // Random games.
        for (int g = 0; g < 12; g++) begin
            do_start();
            for (int k = 0; k < 30 && m_live; k++) begin
                if ($urandom_range(0, 4) == 0) sel = 4'($urandom_range(0, 15));
                else sel = 4'($urandom_range(1, 9));
                do_move(sel, (m_live && sel >= 4'd1 && sel <= 4'd9 && $urandom_range(0, 19) == 0));
                idle($urandom_range(0, 3));
            end
            do_move(4'($urandom_range(1, 9)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
